// File: rtl/otter_pkg.sv
// rtl/otter_pkg.sv - shared OTTER types and constants
package otter_pkg;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    typedef enum logic [6:0] {
        OP_LUI    = 7'b0110111,
        OP_AUIPC  = 7'b0010111,
        OP_JAL    = 7'b1101111,
        OP_JALR   = 7'b1100111,
        OP_BRANCH = 7'b1100011,
        OP_LOAD   = 7'b0000011,
        OP_STORE  = 7'b0100011,
        OP_IMM    = 7'b0010011,
        OP_REG    = 7'b0110011,
        OP_SYSTEM = 7'b1110011
    } opcode_t;

    // One fetched pair; slot-1 PC is implicitly pc + 4.
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] ir;
        logic [31:0] ir_2;
    } fetch_entry_t;

endpackage

// File: rtl/otter_fetch_queue_if.sv
// rtl/otter_fetch_queue_if.sv - fetch stage bus: memory port, decode handshake, redirect
interface otter_fetch_queue_if;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        imem_rd;
    logic [31:0] imem_addr1;
    logic [31:0] imem_addr2;
    logic [31:0] imem_dout1;
    logic [31:0] imem_dout2;
    logic        de_valid;
    logic        de_ready;
    logic [31:0] de_pc;
    logic [31:0] de_ir;
    logic [31:0] de_ir_2;

    modport master (
        input  redirect, redirect_pc, imem_dout1, imem_dout2, de_ready,
        output imem_rd, imem_addr1, imem_addr2, de_valid, de_pc, de_ir, de_ir_2
    );

    modport slave (
        output redirect, redirect_pc, imem_dout1, imem_dout2, de_ready,
        input  imem_rd, imem_addr1, imem_addr2, de_valid, de_pc, de_ir, de_ir_2
    );
endinterface

// File: rtl/otter_sync_fifo.sv
// rtl/otter_sync_fifo.sv - synchronous FIFO with flush; head reads zero when empty
module otter_sync_fifo #(
    parameter int WIDTH = 96,
    parameter int DEPTH = 4
) (
    input  logic                     CLK,
    input  logic                     RESET,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    input  logic                     flush,
    output logic [WIDTH-1:0]         head_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign do_push = push && !flush;
    assign do_pop  = pop && !flush && !empty;

    always_ff @(posedge CLK) begin
        if (RESET || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            if (do_push && !do_pop)
                count <= count + CW'(1);
            else if (!do_push && do_pop)
                count <= count - CW'(1);
        end
    end

    always_ff @(posedge CLK) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

    assign head_data = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/otter_fetch_queue.sv
// rtl/otter_fetch_queue.sv - dual-issue fetch: PC, credit-based requests, pair queue, redirect squash
module otter_fetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = otter_pkg::RESET_PC
) (
    input  logic              CLK,
    input  logic              RESET,
    otter_fetch_queue_if.master bus
);
    import otter_pkg::*;

    localparam int CW = $clog2(DEPTH) + 1;

    logic [31:0]   fetch_pc;
    logic [31:0]   req_pc;
    logic          inflight;
    logic [CW-1:0] count;
    logic          fifo_full;
    logic          fifo_empty;
    logic          issue;
    logic          push;
    logic          pop;
    fetch_entry_t  push_entry;
    fetch_entry_t  head_entry;

    // Credit counts the outstanding response so the queue can never overflow;
    // a pop in the same cycle is deliberately not credited.
    assign bus.imem_rd    = !RESET && ((count + CW'(inflight)) < CW'(DEPTH));
    assign bus.imem_addr1 = fetch_pc;
    assign bus.imem_addr2 = fetch_pc + 32'd4;

    assign issue = bus.imem_rd && !bus.redirect;
    assign push  = inflight && !bus.redirect;
    assign pop   = bus.de_valid && bus.de_ready && !bus.redirect;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            fetch_pc <= RESET_PC;
            req_pc   <= '0;
            inflight <= 1'b0;
        end else if (bus.redirect) begin
            fetch_pc <= bus.redirect_pc;
            inflight <= 1'b0;
        end else begin
            inflight <= issue;
            if (issue) begin
                fetch_pc <= fetch_pc + 32'd8;
                req_pc   <= fetch_pc;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (!RESET) assert (!(push && fifo_full));
    end

    assign push_entry = '{pc: req_pc, ir: bus.imem_dout1, ir_2: bus.imem_dout2};

    otter_sync_fifo #(
        .WIDTH ($bits(fetch_entry_t)),
        .DEPTH (DEPTH)
    ) u_queue (
        .CLK       (CLK),
        .RESET     (RESET),
        .push      (push),
        .push_data (push_entry),
        .pop       (pop),
        .flush     (bus.redirect),
        .head_data (head_entry),
        .count     (count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign bus.de_valid = !fifo_empty;
    assign bus.de_pc    = head_entry.pc;
    assign bus.de_ir    = head_entry.ir;
    assign bus.de_ir_2  = head_entry.ir_2;

endmodule

// File: tb/tb_otter_fetch_queue.sv
// tb/tb_otter_fetch_queue.sv - self-checking bench for otter_fetch_queue
module tb_otter_fetch_queue;
    import otter_pkg::*;

    logic clk = 1'b0;
    logic rst;
    int   checks   = 0;
    int   failures = 0;
    int   n_pops   = 0;
    logic [31:0] last_pop_pc = '0;
    logic [31:0] exp_fpc = '0;
    fetch_entry_t sb[$];

    otter_fetch_queue_if fif();

    otter_fetch_queue #(.DEPTH(4), .RESET_PC(32'h0000_0000)) dut (
        .CLK   (clk),
        .RESET (rst),
        .bus   (fif.master)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] word(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h5A5A_0000;
    endfunction

    // Synchronous-read instruction memory returning address-tagged words
    always @(posedge clk) begin
        if (fif.imem_rd) begin
            fif.imem_dout1 <= word(fif.imem_addr1);
            fif.imem_dout2 <= word(fif.imem_addr2);
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
        end
    endtask

    // Scoreboard: expected pair queued when a request is issued, compared on each accepted pop
    always @(negedge clk) begin
        if (rst) begin
            sb.delete();
            exp_fpc = 32'h0000_0000;
        end else begin
            if (fif.de_valid && fif.de_ready && !fif.redirect) begin
                if (sb.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL sb_unexpected_pop actual_pc=0x%08h required=none", fif.de_pc);
                end else begin
                    fetch_entry_t e;
                    e = sb.pop_front();
                    chk("sb_pc", fif.de_pc, e.pc);
                    chk("sb_ir", fif.de_ir, e.ir);
                    chk("sb_ir_2", fif.de_ir_2, e.ir_2);
                end
                n_pops++;
                last_pop_pc = fif.de_pc;
            end
            if (fif.redirect) begin
                sb.delete();
                exp_fpc = fif.redirect_pc;
            end else if (fif.imem_rd) begin
                chk("addr_track", fif.imem_addr1, exp_fpc);
                sb.push_back('{pc: exp_fpc, ir: word(exp_fpc), ir_2: word(exp_fpc + 32'd4)});
                exp_fpc = exp_fpc + 32'd8;
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        fif.redirect = 1'b0;
        cyc();
        cyc();
        #1;
        chk("rst_imem_rd", 32'(fif.imem_rd), 32'd0);
        chk("rst_de_valid", 32'(fif.de_valid), 32'd0);
        chk("rst_de_pc", fif.de_pc, 32'd0);
        chk("rst_de_ir", fif.de_ir, 32'd0);
        chk("rst_de_ir_2", fif.de_ir_2, 32'd0);
        cyc();
        rst = 1'b0;
    endtask

    typedef struct {
        logic        rdy;
        logic        exp_rd;
        logic [31:0] exp_a1;
        logic        exp_dv;
        logic [31:0] exp_pc;
    } vec_t;

    vec_t vt[6];

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        int base;
        rst = 1'b1;
        fif.redirect = 1'b0;
        fif.redirect_pc = '0;
        fif.de_ready = 1'b0;
        fif.imem_dout1 = '0;
        fif.imem_dout2 = '0;

        // Prime latency and steady streaming with decode always ready
        vt[0] = '{1'b1, 1'b1, 32'h00, 1'b0, 32'h00};
        vt[1] = '{1'b1, 1'b1, 32'h08, 1'b0, 32'h00};
        vt[2] = '{1'b1, 1'b1, 32'h10, 1'b1, 32'h00};
        vt[3] = '{1'b1, 1'b1, 32'h18, 1'b1, 32'h08};
        vt[4] = '{1'b1, 1'b1, 32'h20, 1'b1, 32'h10};
        vt[5] = '{1'b1, 1'b1, 32'h28, 1'b1, 32'h18};
        fif.de_ready = 1'b1;
        do_reset();
        for (int i = 0; i < 6; i++) begin
            fif.de_ready = vt[i].rdy;
            #1;
            chk($sformatf("t1_rd_c%0d", i), 32'(fif.imem_rd), 32'(vt[i].exp_rd));
            chk($sformatf("t1_a1_c%0d", i), fif.imem_addr1, vt[i].exp_a1);
            chk($sformatf("t1_a2_c%0d", i), fif.imem_addr2, vt[i].exp_a1 + 32'd4);
            chk($sformatf("t1_dv_c%0d", i), 32'(fif.de_valid), 32'(vt[i].exp_dv));
            chk($sformatf("t1_pc_c%0d", i), fif.de_pc, vt[i].exp_dv ? vt[i].exp_pc : 32'd0);
            chk($sformatf("t1_ir_c%0d", i), fif.de_ir, vt[i].exp_dv ? word(vt[i].exp_pc) : 32'd0);
            chk($sformatf("t1_ir2_c%0d", i), fif.de_ir_2, vt[i].exp_dv ? word(vt[i].exp_pc + 32'd4) : 32'd0);
            cyc();
        end

        // Backpressure: exactly DEPTH requests, then ordered drain and resume
        fif.de_ready = 1'b0;
        do_reset();
        for (int c = 0; c < 8; c++) begin
            #1;
            chk($sformatf("bp_rd_c%0d", c), 32'(fif.imem_rd), (c < 4) ? 32'd1 : 32'd0);
            if (c < 4) chk($sformatf("bp_a1_c%0d", c), fif.imem_addr1, 32'(c * 8));
            chk($sformatf("bp_dv_c%0d", c), 32'(fif.de_valid), (c >= 2) ? 32'd1 : 32'd0);
            if (c >= 2) chk($sformatf("bp_hold_pc_c%0d", c), fif.de_pc, 32'd0);
            cyc();
        end
        base = n_pops;
        fif.de_ready = 1'b1;
        #1;
        chk("bp_no_credit_same_cycle_pop", 32'(fif.imem_rd), 32'd0);
        cyc();
        #1;
        chk("bp_resume_rd", 32'(fif.imem_rd), 32'd1);
        chk("bp_resume_a1", fif.imem_addr1, 32'h20);
        repeat (5) cyc();
        chk("bp_pop_count", 32'(n_pops - base), 32'd6);
        chk("bp_last_pc", last_pop_pc, 32'h28);

        // Redirect with 3 queued entries and a response in flight
        fif.de_ready = 1'b0;
        do_reset();
        repeat (4) cyc();
        #1;
        chk("rd_pre_dv", 32'(fif.de_valid), 32'd1);
        fif.redirect = 1'b1;
        fif.redirect_pc = 32'h104;
        cyc();
        fif.redirect = 1'b0;
        #1;
        chk("rd_r1_dv", 32'(fif.de_valid), 32'd0);
        chk("rd_r1_pc_zero", fif.de_pc, 32'd0);
        chk("rd_r1_rd", 32'(fif.imem_rd), 32'd1);
        chk("rd_r1_a1", fif.imem_addr1, 32'h104);
        chk("rd_r1_a2", fif.imem_addr2, 32'h108);
        cyc();
        #1;
        chk("rd_r2_dv", 32'(fif.de_valid), 32'd0);
        cyc();
        #1;
        chk("rd_r3_dv", 32'(fif.de_valid), 32'd1);
        chk("rd_r3_pc", fif.de_pc, 32'h104);
        chk("rd_r3_ir", fif.de_ir, word(32'h104));
        chk("rd_r3_ir_2", fif.de_ir_2, word(32'h108));
        fif.de_ready = 1'b1;
        cyc();
        cyc();

        // Redirect coinciding with an accepted-looking head
        #1;
        chk("rr_pre_dv", 32'(fif.de_valid), 32'd1);
        base = n_pops;
        fif.redirect = 1'b1;
        fif.redirect_pc = 32'h200;
        cyc();
        fif.redirect = 1'b0;
        #1;
        chk("rr_r1_dv", 32'(fif.de_valid), 32'd0);
        cyc();
        cyc();
        #1;
        chk("rr_r3_dv", 32'(fif.de_valid), 32'd1);
        chk("rr_r3_pc", fif.de_pc, 32'h200);
        chk("rr_no_pops", 32'(n_pops - base), 32'd0);
        cyc();

        // Redirect near the top of the address space wraps
        fif.redirect = 1'b1;
        fif.redirect_pc = 32'hFFFF_FFF8;
        cyc();
        fif.redirect = 1'b0;
        #1;
        chk("wr_r1_a1", fif.imem_addr1, 32'hFFFF_FFF8);
        chk("wr_r1_a2", fif.imem_addr2, 32'hFFFF_FFFC);
        cyc();
        #1;
        chk("wr_r2_a1", fif.imem_addr1, 32'h0000_0000);
        chk("wr_r2_a2", fif.imem_addr2, 32'h0000_0004);
        cyc();
        #1;
        chk("wr_r3_pc", fif.de_pc, 32'hFFFF_FFF8);
        chk("wr_r3_ir_2", fif.de_ir_2, word(32'hFFFF_FFFC));
        repeat (3) cyc();

        // One-cycle reset pulse with a full queue
        fif.de_ready = 1'b0;
        repeat (8) cyc();
        #1;
        chk("rp_full_dv", 32'(fif.de_valid), 32'd1);
        chk("rp_full_rd", 32'(fif.imem_rd), 32'd0);
        rst = 1'b1;
        #1;
        chk("rp_rst_rd", 32'(fif.imem_rd), 32'd0);
        cyc();
        rst = 1'b0;
        #1;
        chk("rp_c0_dv", 32'(fif.de_valid), 32'd0);
        chk("rp_c0_pc", fif.de_pc, 32'd0);
        chk("rp_c0_rd", 32'(fif.imem_rd), 32'd1);
        chk("rp_c0_a1", fif.imem_addr1, 32'd0);
        cyc();
        #1;
        chk("rp_c1_dv", 32'(fif.de_valid), 32'd0);
        cyc();
        #1;
        chk("rp_c2_dv", 32'(fif.de_valid), 32'd1);
        chk("rp_c2_pc", fif.de_pc, 32'd0);
        chk("rp_c2_ir", fif.de_ir, word(32'd0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
